// File: rtl/ixu_branch_resolve.sv
// ixu_branch_resolve
//   Two-stage branch resolution unit for the integer execution cluster.
//   S1 registers the op fields and the operand compares (eq, signed >,
//   unsigned >). S2 resolves the condition, target, link/AUIPC result and
//   the mispredict check against the frontend prediction. S2 is the output
//   register. Both sides use a valid/ready handshake, and flush_i kills all
//   in-flight ops.
// Ports
//   cpu_clock_i, cpu_reset_i (sync, active high), flush_i
//   valid_i / ready_o        : op input handshake with the op fields
//                              (rob_id_i, operands, offset_i, pc_i, op class,
//                              bnch_cond_i, btb_* prediction, bm_pred_i)
//   valid_o / ready_i        : resolved op handshake towards the RCU
//   rob_id_o, result_o, excp_o, excp_addr_o, brnch_res_o, branch_type_o
//   btb_bm_mod_o, call_affirm_o, ret_affirm_o : training strobes
//   branch_cnt_o, mispredict_cnt_o             : wrapping perf counters
module ixu_branch_resolve #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             cpu_clock_i,
  input  logic             cpu_reset_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [ROB_W-1:0] rob_id_i,
  input  logic [XLEN-1:0]  operand_1_i,
  input  logic [XLEN-1:0]  operand_2_i,
  input  logic [XLEN-1:0]  offset_i,
  input  logic [XLEN-3:0]  pc_i,
  input  logic             auipc_i,
  input  logic             call_i,
  input  logic             ret_i,
  input  logic             jal_i,
  input  logic             jalr_i,
  input  logic [2:0]       bnch_cond_i,
  input  logic             btb_vld_i,
  input  logic [XLEN-3:0]  btb_target_i,
  input  logic [1:0]       btype_i,
  input  logic [1:0]       bm_pred_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [ROB_W-1:0] rob_id_o,
  output logic [XLEN-1:0]  result_o,
  output logic             excp_o,
  output logic [XLEN-1:0]  excp_addr_o,
  output logic             brnch_res_o,
  output logic [1:0]       branch_type_o,
  output logic             btb_bm_mod_o,
  output logic             call_affirm_o,
  output logic             ret_affirm_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  localparam int PW = XLEN - 2;
  localparam logic [XLEN-1:0]  WORD_STEP = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [PW-1:0]    PC_ONE    = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Stage 1 registers
  logic             s1_vld_r;
  logic [ROB_W-1:0] s1_rob_r;
  logic [XLEN-1:0]  s1_op1_r, s1_off_r;
  logic [PW-1:0]    s1_pc_r, s1_btb_tgt_r;
  logic             s1_auipc_r, s1_call_r, s1_ret_r, s1_jal_r, s1_jalr_r;
  logic [2:0]       s1_cond_r;
  logic             s1_btb_vld_r, s1_bm_taken_r;
  logic [1:0]       s1_btype_r;
  logic             s1_eq_r, s1_sgt_r, s1_ugt_r;

  // Stage 2 (output) registers
  logic             s2_vld_r, s2_excp_r, s2_bm_mod_r, s2_call_aff_r, s2_ret_aff_r;
  logic [ROB_W-1:0] s2_rob_r;
  logic [XLEN-1:0]  s2_result_r, s2_addr_r;
  logic             s2_taken_r, s2_auipc_r;
  logic [1:0]       s2_type_r;
  logic [CNT_W-1:0] branch_cnt_r, mispredict_cnt_r;

  // Resolve-stage combinational results
  logic             s2_en_s, s1_en_s, retire_s;
  logic             lt_s, cond_s, taken_s, redirect_s, mis_s, good_s;
  logic [XLEN-1:0]  base_s, inc_s, sum_s, target_s, result_s;
  logic [PW-1:0]    pc_inc_s;
  logic [1:0]       type_s;

  // S2 can take a new op when empty or draining; S1 moves whenever S2 can.
  assign s2_en_s  = !s2_vld_r | ready_i;
  assign s1_en_s  = !s1_vld_r | s2_en_s;
  assign ready_o  = s1_en_s;
  assign retire_s = s2_vld_r & ready_i & !flush_i;

  // S1 valid: cleared by reset or flush, otherwise follows the input when moving.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      s1_vld_r <= 1'b0;
    end else if (flush_i) begin
      s1_vld_r <= 1'b0;
    end else if (s1_en_s) begin
      s1_vld_r <= valid_i;
    end else begin
      s1_vld_r <= s1_vld_r;
    end
  end

  // S1 payload and operand compares, captured on accept.
  always_ff @(posedge cpu_clock_i) begin
    if (s1_en_s && valid_i) begin
      s1_rob_r      <= rob_id_i;
      s1_op1_r      <= operand_1_i;
      s1_off_r      <= offset_i;
      s1_pc_r       <= pc_i;
      s1_auipc_r    <= auipc_i;
      s1_call_r     <= call_i;
      s1_ret_r      <= ret_i;
      s1_jal_r      <= jal_i;
      s1_jalr_r     <= jalr_i;
      s1_cond_r     <= bnch_cond_i;
      s1_btb_vld_r  <= btb_vld_i;
      s1_btb_tgt_r  <= btb_target_i;
      s1_btype_r    <= btype_i;
      s1_bm_taken_r <= bm_pred_i[1];
      s1_eq_r       <= (operand_1_i == operand_2_i);
      s1_sgt_r      <= ($signed(operand_1_i) > $signed(operand_2_i));
      s1_ugt_r      <= (operand_1_i > operand_2_i);
    end
  end

  // Resolve condition, target, type, result and the mispredict check.
  always_comb begin
    // lt is neither greater nor equal; funct3[1] selects the unsigned compare
    if (s1_cond_r[1]) begin
      lt_s = !s1_ugt_r & !s1_eq_r;
    end else begin
      lt_s = !s1_sgt_r & !s1_eq_r;
    end
    case ({s1_cond_r[2], s1_cond_r[0]})
      2'b00:   cond_s = s1_eq_r;
      2'b01:   cond_s = !s1_eq_r;
      2'b10:   cond_s = lt_s;
      2'b11:   cond_s = !lt_s;
      default: cond_s = 1'b0;
    endcase
    // Only a plain conditional branch reports a condition outcome
    taken_s = cond_s & !(s1_auipc_r | s1_call_r | s1_ret_r | s1_jal_r | s1_jalr_r);

    if (s1_jalr_r) begin
      base_s = s1_op1_r;
    end else begin
      base_s = {s1_pc_r, 2'b00};
    end
    if ((s1_jal_r | s1_jalr_r | taken_s) & !s1_auipc_r) begin
      inc_s = s1_off_r;
    end else begin
      inc_s = WORD_STEP;
    end
    sum_s    = base_s + inc_s;
    target_s = {sum_s[XLEN-1:1], sum_s[0] & !s1_jalr_r};

    if (s1_call_r) begin
      type_s = 2'b01;
    end else if (s1_ret_r) begin
      type_s = 2'b11;
    end else if (s1_jal_r | s1_jalr_r) begin
      type_s = 2'b10;
    end else begin
      type_s = 2'b00;
    end

    pc_inc_s = s1_pc_r + PC_ONE;
    if (s1_auipc_r) begin
      result_s = {s1_pc_r, 2'b00} + s1_off_r;
    end else begin
      result_s = {pc_inc_s, 2'b00};
    end

    redirect_s = taken_s | (type_s != 2'b00);
    if (s1_auipc_r) begin
      mis_s = 1'b0;
    end else if (!s1_btb_vld_r) begin
      mis_s = redirect_s;
    end else begin
      mis_s = (type_s != s1_btype_r)
            | ((type_s == 2'b00) & (taken_s ^ s1_bm_taken_r))
            | (redirect_s & ({s1_btb_tgt_r, 2'b00} != target_s));
    end
    good_s = s1_btb_vld_r & !mis_s & !s1_auipc_r;
  end

  // S2 valid, exception and strobes; kept qualified so they read 0 when idle.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i || flush_i) begin
      s2_vld_r      <= 1'b0;
      s2_excp_r     <= 1'b0;
      s2_bm_mod_r   <= 1'b0;
      s2_call_aff_r <= 1'b0;
      s2_ret_aff_r  <= 1'b0;
    end else if (s2_en_s) begin
      s2_vld_r      <= s1_vld_r;
      s2_excp_r     <= s1_vld_r & mis_s;
      s2_bm_mod_r   <= s1_vld_r & good_s & !(s1_call_r | s1_ret_r);
      s2_call_aff_r <= s1_vld_r & good_s & s1_call_r;
      s2_ret_aff_r  <= s1_vld_r & good_s & s1_ret_r;
    end else begin
      s2_vld_r      <= s2_vld_r;
      s2_excp_r     <= s2_excp_r;
      s2_bm_mod_r   <= s2_bm_mod_r;
      s2_call_aff_r <= s2_call_aff_r;
      s2_ret_aff_r  <= s2_ret_aff_r;
    end
  end

  // S2 payload, loaded only when a valid op moves up from S1.
  always_ff @(posedge cpu_clock_i) begin
    if (s2_en_s && s1_vld_r) begin
      s2_rob_r    <= s1_rob_r;
      s2_result_r <= result_s;
      s2_addr_r   <= target_s;
      s2_taken_r  <= taken_s;
      s2_type_r   <= type_s;
      s2_auipc_r  <= s1_auipc_r;
    end
  end

  // Perf counters advance on each retired (accepted, unflushed) op.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      branch_cnt_r     <= {CNT_W{1'b0}};
      mispredict_cnt_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      branch_cnt_r     <= s2_auipc_r ? branch_cnt_r : branch_cnt_r + CNT_ONE;
      mispredict_cnt_r <= s2_excp_r ? mispredict_cnt_r + CNT_ONE : mispredict_cnt_r;
    end else begin
      branch_cnt_r     <= branch_cnt_r;
      mispredict_cnt_r <= mispredict_cnt_r;
    end
  end

  assign valid_o          = s2_vld_r;
  assign rob_id_o         = s2_rob_r;
  assign result_o         = s2_result_r;
  assign excp_o           = s2_excp_r;
  assign excp_addr_o      = s2_addr_r;
  assign brnch_res_o      = s2_taken_r;
  assign branch_type_o    = s2_type_r;
  assign btb_bm_mod_o     = s2_bm_mod_r;
  assign call_affirm_o    = s2_call_aff_r;
  assign ret_affirm_o     = s2_ret_aff_r;
  assign branch_cnt_o     = branch_cnt_r;
  assign mispredict_cnt_o = mispredict_cnt_r;

endmodule

// File: tb/tb_ixu_branch_resolve.sv
module tb_ixu_branch_resolve;

  typedef struct packed {
    logic [5:0]  rob;
    logic [31:0] a, b, off;
    logic [29:0] pc;
    logic        auipc, call, ret, jal, jalr;
    logic [2:0]  bc;
    logic        btb_vld;
    logic [29:0] btgt;
    logic [1:0]  btype;
    logic [1:0]  bm;
  } op_t;

  typedef struct packed {
    logic [5:0]  rob;
    logic [31:0] result, addr;
    logic        excp, taken;
    logic [1:0]  btype;
    logic        bm_mod, call_aff, ret_aff, auipc;
  } exp_t;

  logic        clk = 1'b0;
  logic        cpu_reset_i, flush_i, valid_i, ready_i;
  logic        ready_o, valid_o, excp_o, brnch_res_o;
  logic        btb_bm_mod_o, call_affirm_o, ret_affirm_o;
  logic [5:0]  rob_id_o;
  logic [31:0] result_o, excp_addr_o, branch_cnt_o, mispredict_cnt_o;
  logic [1:0]  branch_type_o;
  op_t         cur;
  bit          rdy_cfg;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_err = 0;
  int unsigned cnt_br = 0;
  int unsigned cnt_mis = 0;

  always #5 clk = ~clk;

  ixu_branch_resolve #(.XLEN(32), .ROB_W(6), .CNT_W(32)) dut (
    .cpu_clock_i(clk), .cpu_reset_i(cpu_reset_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .rob_id_i(cur.rob),
    .operand_1_i(cur.a), .operand_2_i(cur.b), .offset_i(cur.off), .pc_i(cur.pc),
    .auipc_i(cur.auipc), .call_i(cur.call), .ret_i(cur.ret), .jal_i(cur.jal),
    .jalr_i(cur.jalr), .bnch_cond_i(cur.bc), .btb_vld_i(cur.btb_vld),
    .btb_target_i(cur.btgt), .btype_i(cur.btype), .bm_pred_i(cur.bm),
    .valid_o(valid_o), .ready_i(ready_i), .rob_id_o(rob_id_o), .result_o(result_o),
    .excp_o(excp_o), .excp_addr_o(excp_addr_o), .brnch_res_o(brnch_res_o),
    .branch_type_o(branch_type_o), .btb_bm_mod_o(btb_bm_mod_o),
    .call_affirm_o(call_affirm_o), .ret_affirm_o(ret_affirm_o),
    .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: resolves one op straight from the architectural rules.
  function automatic exp_t model(input op_t o);
    exp_t        e;
    logic        lt, cond, taken, jump, redirect, mis, good;
    logic [31:0] pcb, tgt;
    logic [1:0]  t;
    pcb = {o.pc, 2'b00};
    lt  = o.bc[1] ? (o.a < o.b) : ($signed(o.a) < $signed(o.b));
    case ({o.bc[2], o.bc[0]})
      2'b00:   cond = (o.a == o.b);
      2'b01:   cond = (o.a != o.b);
      2'b10:   cond = lt;
      default: cond = !lt;
    endcase
    jump  = o.jal || o.jalr;
    taken = cond && !(o.auipc || o.call || o.ret || jump);
    tgt   = (o.jalr ? o.a : pcb) + (((jump || taken) && !o.auipc) ? o.off : 32'd4);
    if (o.jalr) tgt = tgt & 32'hFFFF_FFFE;
    t = o.call ? 2'd1 : (o.ret ? 2'd3 : (jump ? 2'd2 : 2'd0));
    redirect = taken || (t != 2'd0);
    if (o.auipc) mis = 1'b0;
    else if (!o.btb_vld) mis = redirect;
    else mis = (t != o.btype) || ((t == 2'd0) && (taken != o.bm[1]))
            || (redirect && ({o.btgt, 2'b00} != tgt));
    good       = o.btb_vld && !mis && !o.auipc;
    e.rob      = o.rob;
    e.result   = o.auipc ? pcb + o.off : pcb + 32'd4;
    e.addr     = tgt;
    e.excp     = mis;
    e.taken    = taken;
    e.btype    = t;
    e.bm_mod   = good && !o.call && !o.ret;
    e.call_aff = good && o.call;
    e.ret_aff  = good && o.ret;
    e.auipc    = o.auipc;
    return e;
  endfunction

  function automatic op_t rand_op();
    op_t         o;
    exp_t        e;
    logic [12:0] imm;
    int          k;
    o     = '0;
    o.rob = 6'($urandom);
    o.a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom;
    k     = $urandom_range(0, 3);
    o.b   = (k == 0) ? o.a : ((k == 1) ? ~o.a : $urandom);
    imm   = 13'($urandom);
    o.off = {{19{imm[12]}}, imm};
    o.pc  = 30'($urandom);
    o.bc  = 3'($urandom);
    k     = $urandom_range(0, 8);
    o.jal   = (k == 3) || (k == 5);
    o.jalr  = (k == 4) || (k >= 6 && k <= 7);
    o.call  = (k == 5) || (k == 6);
    o.ret   = (k == 7);
    o.auipc = (k == 8);
    e = model(o);
    if ($urandom_range(0, 1) == 1) begin
      o.btb_vld = 1'b1;
      o.btgt    = e.addr[31:2];
      o.btype   = e.btype;
      o.bm      = {e.taken, 1'($urandom)};
    end else begin
      o.btb_vld = 1'($urandom);
      o.btgt    = ($urandom_range(0, 1) == 1) ? e.addr[31:2] : 30'($urandom);
      o.btype   = 2'($urandom);
      o.bm      = 2'($urandom);
    end
    return o;
  endfunction

  task automatic issue(input op_t o);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      ready_i = rdy_cfg; flush_i = 1'b0; cur = o; valid_i = 1'b1;
      #1;
      if (ready_o) begin
        sb.push_back(model(o));
        done = 1'b1;
      end
    end
    if (!done) begin
      valid_i = 1'b0;
      chk("issue_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0; ready_i = rdy_cfg;
  endtask

  // Monitor: pops the scoreboard on every output handshake, tracks counters
  // and checks that a stalled output holds still.
  initial begin
    exp_t        e;
    bit          hold_pending;
    logic [63:0] hold_data;
    logic [12:0] hold_ctl;
    hold_pending = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (cpu_reset_i) begin
        sb.delete();
        cnt_br = 0; cnt_mis = 0;
        hold_pending = 1'b0;
      end else begin
        chk("cnt_branch", branch_cnt_o, cnt_br);
        chk("cnt_mispredict", mispredict_cnt_o, cnt_mis);
        if (hold_pending) begin
          chk("hold_valid", valid_o, 1'b1);
          chk("hold_data", {result_o, excp_addr_o}, hold_data);
          chk("hold_ctl", {rob_id_o, excp_o, brnch_res_o, branch_type_o,
                           btb_bm_mod_o, call_affirm_o, ret_affirm_o}, hold_ctl);
        end
        if (valid_o && ready_i && !flush_i) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("rob_id", rob_id_o, e.rob);
            chk("result", result_o, e.result);
            chk("excp", excp_o, e.excp);
            chk("excp_addr", excp_addr_o, e.addr);
            chk("brnch_res", brnch_res_o, e.taken);
            chk("branch_type", branch_type_o, e.btype);
            chk("strobes", {btb_bm_mod_o, call_affirm_o, ret_affirm_o},
                {e.bm_mod, e.call_aff, e.ret_aff});
            if (!e.auipc) cnt_br++;
            if (e.excp) cnt_mis++;
          end
        end
        hold_pending = valid_o && !ready_i && !flush_i;
        hold_data    = {result_o, excp_addr_o};
        hold_ctl     = {rob_id_o, excp_o, brnch_res_o, branch_type_o,
                        btb_bm_mod_o, call_affirm_o, ret_affirm_o};
        if (flush_i) sb.delete();
      end
    end
  end

  initial begin
    op_t         o;
    int unsigned br_snap, mis_snap;
    cur = '0; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
    cpu_reset_i = 1'b1; rdy_cfg = 1'b1;
    repeat (3) @(negedge clk);
    cpu_reset_i = 1'b0;
    #2;
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_excp", excp_o, 1'b0);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_strobes", {btb_bm_mod_o, call_affirm_o, ret_affirm_o}, 3'b000);
    chk("rst_cnt", {branch_cnt_o, mispredict_cnt_o}, 64'd0);

    // beq taken, correctly predicted
    o = '0; o.rob = 6'd1; o.a = 32'd5; o.b = 32'd5; o.pc = 30'h40; o.off = 32'h40;
    o.btb_vld = 1'b1; o.btgt = 30'h50; o.btype = 2'b00; o.bm = 2'b11;
    issue(o);
    idle(); #2 chk("beq_early", valid_o, 1'b0);
    idle(); #2 chk("beq_valid", valid_o, 1'b1);
    chk("beq_excp", excp_o, 1'b0);
    chk("beq_bm_mod", btb_bm_mod_o, 1'b1);
    idle(); #2 chk("beq_cnt", branch_cnt_o, 32'd1);

    // bltu not taken against a taken prediction
    o = '0; o.rob = 6'd2; o.a = 32'hFFFF_FFFF; o.b = 32'd1; o.bc = 3'b110;
    o.pc = 30'h40; o.off = 32'h40; o.btb_vld = 1'b1; o.btgt = 30'h50; o.bm = 2'b10;
    issue(o);
    idle(); idle(); #2;
    chk("bltu_excp", excp_o, 1'b1);
    chk("bltu_addr", excp_addr_o, 32'h104);
    idle(); #2 chk("bltu_miscnt", mispredict_cnt_o, 32'd1);

    // unpredicted jalr call
    o = '0; o.rob = 6'd3; o.a = 32'h2003; o.jalr = 1'b1; o.call = 1'b1; o.pc = 30'h40;
    issue(o);
    idle(); idle(); #2;
    chk("jalr_excp", excp_o, 1'b1);
    chk("jalr_addr", excp_addr_o, 32'h2002);
    chk("jalr_result", result_o, 32'h104);
    chk("jalr_type", branch_type_o, 2'b01);
    idle();

    // auipc
    o = '0; o.rob = 6'd4; o.auipc = 1'b1; o.pc = 30'h40; o.off = 32'h1000;
    o.btb_vld = 1'b1; o.btgt = 30'h41;
    issue(o);
    idle(); idle(); #2;
    chk("auipc_result", result_o, 32'h1100);
    chk("auipc_excp", excp_o, 1'b0);
    chk("auipc_strobes", {btb_bm_mod_o, call_affirm_o, ret_affirm_o}, 3'b000);
    idle(); #2 chk("auipc_cnt", branch_cnt_o, 32'd3);

    // back-to-back with the RCU stalled
    rdy_cfg = 1'b0;
    issue(rand_op());
    issue(rand_op());
    @(negedge clk);
    ready_i = 1'b0; cur = rand_op(); valid_i = 1'b1;
    #1 chk("stall_ready", ready_o, 1'b0);
    o = cur;
    repeat (2) @(negedge clk);
    rdy_cfg = 1'b1;
    issue(o);
    repeat (6) idle();

    // flush with both stages and the input valid
    rdy_cfg = 1'b0;
    issue(rand_op());
    issue(rand_op());
    br_snap = cnt_br; mis_snap = cnt_mis;
    @(negedge clk);
    ready_i = 1'b0; cur = rand_op(); valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk);
    idle(); #2;
    chk("flush_valid", valid_o, 1'b0);
    chk("flush_cnt", {branch_cnt_o, mispredict_cnt_o}, {br_snap, mis_snap});
    rdy_cfg = 1'b1;
    idle(); idle(); #2 chk("flush_dropped", valid_o, 1'b0);

    // reset mid-operation
    rdy_cfg = 1'b0;
    issue(rand_op());
    issue(rand_op());
    @(negedge clk);
    valid_i = 1'b0; cpu_reset_i = 1'b1;
    @(negedge clk);
    cpu_reset_i = 1'b0;
    #2;
    chk("rst_mid_valid", valid_o, 1'b0);
    chk("rst_mid_ready", ready_o, 1'b1);
    chk("rst_mid_cnt", {branch_cnt_o, mispredict_cnt_o}, 64'd0);

    // randomized traffic with random backpressure and occasional flush
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        ready_i = 1'b0; flush_i = 1'b1; cur = rand_op(); valid_i = 1'($urandom);
      end else begin
        flush_i = 1'b0;
        ready_i = ($urandom_range(0, 3) != 0);
        valid_i = ($urandom_range(0, 9) < 7);
        cur = rand_op();
        #1;
        if (valid_i && ready_o) sb.push_back(model(cur));
      end
    end

    // drain with a bounded wait
    rdy_cfg = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) idle();
    chk("drain", sb.size(), 0);
    idle(); idle();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
